// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer and the AXI register block.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT_ACC, WRITE, FINISH
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Dimension ports must be able to express MAX+1 so oversize requests are detectable.
  function automatic int calc_idx_w(input int max_m, input int max_k, input int max_n);
    return $clog2(max3(max_m, max_k, max_n) + 1);
  endfunction

  function automatic int calc_addr_w(input int max_m, input int max_k, input int max_n);
    int w;
    w = $clog2(max3(max_m * max_k, max_k * max_n, max_m * max_n));
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic dims_legal(input int m, input int k, input int n,
                                      input int max_m, input int max_k, input int max_n);
    return (m >= 1) && (m <= max_m) && (k >= 1) && (k <= max_k) &&
           (n >= 1) && (n <= max_n);
  endfunction

endpackage

// File: rtl/matmul_loop_ctr.sv
// i/j/k loop counters with running A/B/C row offsets; addresses are built from adders only.
module matmul_loop_ctr #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              k_step,
  input  logic              dot_step,
  input  logic [IDX_W-1:0]  dim_m,
  input  logic [IDX_W-1:0]  dim_k,
  input  logic [IDX_W-1:0]  dim_n,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr,
  output logic              k_first,
  output logic              k_last,
  output logic              j_last,
  output logic              i_last
);

  logic [IDX_W-1:0]  i_reg, j_reg, k_reg;
  logic [ADDR_W-1:0] a_row_reg, b_row_reg, c_row_reg;
  logic [ADDR_W-1:0] k_ext, n_ext;

  assign k_ext = ADDR_W'(dim_k);
  assign n_ext = ADDR_W'(dim_n);

  // a_row = i*K, b_row = k*N, c_row = i*N
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      a_row_reg <= '0;
      b_row_reg <= '0;
      c_row_reg <= '0;
    end else if (clear) begin
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      a_row_reg <= '0;
      b_row_reg <= '0;
      c_row_reg <= '0;
    end else if (dot_step) begin
      k_reg     <= '0;
      b_row_reg <= '0;
      if (j_last) begin
        j_reg     <= '0;
        i_reg     <= i_reg + IDX_W'(1);
        a_row_reg <= a_row_reg + k_ext;
        c_row_reg <= c_row_reg + n_ext;
      end else begin
        j_reg <= j_reg + IDX_W'(1);
      end
    end else if (k_step) begin
      k_reg     <= k_reg + IDX_W'(1);
      b_row_reg <= b_row_reg + n_ext;
    end
  end

  assign a_addr  = a_row_reg + ADDR_W'(k_reg);
  assign b_addr  = b_row_reg + ADDR_W'(j_reg);
  assign c_addr  = c_row_reg + ADDR_W'(j_reg);
  assign k_first = (k_reg == '0);
  assign k_last  = (k_reg == dim_k - IDX_W'(1));
  assign j_last  = (j_reg == dim_n - IDX_W'(1));
  assign i_last  = (i_reg == dim_m - IDX_W'(1));

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for one C = A x B job over the operand BRAMs and shared MAC.
// Optional busy-cycle counter enabled by defining MATMUL_SEQ_PERF_EN.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int MAX_M  = 4,
  parameter int MAX_K  = 4,
  parameter int MAX_N  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = calc_idx_w(MAX_M, MAX_K, MAX_N),
  parameter int ADDR_W = calc_addr_w(MAX_M, MAX_K, MAX_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  dim_m,
  input  logic [IDX_W-1:0]  dim_k,
  input  logic [IDX_W-1:0]  dim_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              a_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_rdata,
  output logic              b_en,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic              mac_first,
  output logic              mac_last,
  input  logic              acc_valid,
  input  logic [DATA_W-1:0] acc_data,
  output logic              c_we,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  output logic [31:0]       perf_cycles
);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   dm_reg, dk_reg, dn_reg;
  logic               bad_reg, err_reg, done_reg;
  logic [DATA_W-1:0]  result_reg;
  logic               accept, legal, k_step, dot_step;
  logic               k_first, k_last, j_last, i_last;

  assign accept = (state_reg == IDLE) && start;
  assign legal  = dims_legal(int'(dim_m), int'(dim_k), int'(dim_n), MAX_M, MAX_K, MAX_N);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      dm_reg     <= '0;
      dk_reg     <= '0;
      dn_reg     <= '0;
      bad_reg    <= 1'b0;
      err_reg    <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == FINISH);
      if (accept) begin
        dm_reg  <= dim_m;
        dk_reg  <= dim_k;
        dn_reg  <= dim_n;
        bad_reg <= !legal;
        err_reg <= 1'b0;
      end else if (state_reg == FINISH && bad_reg) begin
        err_reg <= 1'b1;
      end
      if (state_reg == WAIT_ACC && acc_valid)
        result_reg <= acc_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_en       = 1'b0;
    b_en       = 1'b0;
    mac_valid  = 1'b0;
    mac_first  = 1'b0;
    mac_last   = 1'b0;
    c_we       = 1'b0;
    k_step     = 1'b0;
    dot_step   = 1'b0;
    case (state_reg)
      IDLE:     if (start) state_next = legal ? FETCH : FINISH;
      FETCH: begin
        a_en       = 1'b1;
        b_en       = 1'b1;
        state_next = ISSUE;
      end
      ISSUE: begin
        mac_valid = 1'b1;
        mac_first = k_first;
        mac_last  = k_last;
        if (mac_ready) begin
          k_step     = !k_last;
          state_next = k_last ? WAIT_ACC : FETCH;
        end
      end
      WAIT_ACC: if (acc_valid) state_next = WRITE;
      WRITE: begin
        c_we       = 1'b1;
        dot_step   = 1'b1;
        state_next = (i_last && j_last) ? FINISH : FETCH;
      end
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  matmul_loop_ctr #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .k_step   (k_step),
    .dot_step (dot_step),
    .dim_m    (dm_reg),
    .dim_k    (dk_reg),
    .dim_n    (dn_reg),
    .a_addr   (a_addr),
    .b_addr   (b_addr),
    .c_addr   (c_addr),
    .k_first  (k_first),
    .k_last   (k_last),
    .j_last   (j_last),
    .i_last   (i_last)
  );

  // Operands pass straight from the BRAM read ports; zero outside ISSUE.
  assign mac_a   = (state_reg == ISSUE) ? a_rdata : '0;
  assign mac_b   = (state_reg == ISSUE) ? b_rdata : '0;
  assign c_wdata = result_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign err     = err_reg;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_reg <= '0;
    else if (accept) perf_reg <= '0;
    else if (busy)   perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cycles = perf_reg;
`else
  assign perf_cycles = '0;
`endif

endmodule
